gpio_irq_top: RTL
=================

# gpio_irq_top

Parametrised Wishbone GPIO controller with per-pin direction, atomic set/clear of outputs, metastability-hardened inputs and per-pin edge interrupts. It is the next generation of the peripheral GPIO block and sits on the SoC Wishbone peripheral bus. It drives the chip-level pad ring through split in/out/enable vectors, and raises one level interrupt to the CPU interrupt controller.

## Interface
- PORT_NUM, 32: number of pins, 1..128; organised as banks of 32, bank count NB = ceil(PORT_NUM/32).
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- wb_cyc_i, wb_stb_i  in  1  Wishbone cycle/strobe.
- wb_adr_i  in  32  byte address; only [6:2] decoded.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lanes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  acknowledge.
- gpio_in_i  in  PORT_NUM  asynchronous pad inputs.
- gpio_out_o  out  PORT_NUM  pad output values (OUT register).
- gpio_oe_o  out  PORT_NUM  pad output enables (DIR register; 1 = drive).
- irq_o  out  1  level interrupt, registered.

## Operation
- Decode: bank = wb_adr_i[3:2], reg = wb_adr_i[6:4].
- Registers, per bank:
  - 0 DIR: RW.
  - 1 OUT: RW.
  - 2 IN: RO, synchronised pad value.
  - 3 IE: RW, interrupt enable.
  - 4 EDGE: RW; 0 = rising, 1 = falling.
  - 5 ISTAT: write-1-to-clear; reads pending status.
  - 6 OUT_SET: WO, OUT |= data.
  - 7 OUT_CLR: WO, OUT &= ~data.
  - Registers 6 and 7 read 0.
- Byte-lane writes honour wb_sel_i; OUT_SET/OUT_CLR/ISTAT bits in disabled lanes are unaffected.
- Bits at or above PORT_NUM, and banks >= NB, ignore writes and read 0.
- Each gpio_in_i bit passes through a SYNC_STAGES flop chain, then one "previous" flop.
- An edge is detected when synced != previous in the EDGE-selected direction. It sets the ISTAT bit only when DIR = 0 for that pin; IE does not gate capture.
- Edge detection is armed only after SYNC_STAGES+1 cycles following reset release (arm counter), so pins held high through reset raise no spurious edge.
- Same-cycle ISTAT W1C and new edge on the same bit: the set wins, bit stays 1.
- irq_o <= |(ISTAT & IE) over all banks, registered each cycle.
- Reset values: DIR, OUT, IE, EDGE, ISTAT, synchroniser and previous flops, arm counter, wb_ack_o, wb_dat_o, irq_o all 0. gpio_oe_o = 0, so all pins are inputs.
- Reset assertion mid-transfer clears wb_ack_o immediately; the master must restart the cycle.

## Timing
- Bus:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o, giving a one-cycle pulse exactly one cycle after strobe. A held strobe acks every other cycle.
  - Write takes effect on the clock edge that raises wb_ack_o.
  - wb_dat_o is valid in the ack cycle and holds its value otherwise.
- Output path: DIR/OUT change visible on gpio_oe_o/gpio_out_o in the ack cycle.
- Input path, from the first clock edge sampling the new pad level:
  - IN updates after SYNC_STAGES edges.
  - ISTAT sets at SYNC_STAGES+1.
  - irq_o asserts at SYNC_STAGES+2 (when IE = 1).
- Read of IN in the same cycle IN updates returns the pre-update value.

## Structure
- gpio_pkg holds:
  - register index localparams (REG_DIR..REG_OUT_CLR);
  - BANK_W = 32;
  - MAX_PORT_NUM = 128.
- Sub-module gpio_sync: per-pin SYNC_STAGES synchroniser plus previous flop, with rise/fall pulse outputs. Parametrised by width and depth, instantiated once with width PORT_NUM.
- Top level holds the register file, arm counter, bus FSM and irq reduction.

## Test plan
- Reset, then read all 8 registers of bank 0 -> every read returns 0; gpio_oe_o = 0; irq_o = 0.
- DIR = 0x0000_00FF, OUT_SET = 0x0F, then OUT_CLR = 0x03 -> gpio_out_o[7:0] = 0x0C, gpio_oe_o[7:0] = 0xFF, OUT reads 0x0C.
- IE[4] = 1, EDGE = 0, gpio_in_i[4] 0->1 -> ISTAT reads 0x10 and irq_o high at edge+4 (SYNC_STAGES = 2). W1C 0x10 -> irq_o low two cycles later.
- Same-cycle W1C of ISTAT[4] and a new rising edge on pin 4 -> ISTAT[4] remains 1.
- Hold gpio_in_i all-ones through reset -> ISTAT stays 0. PORT_NUM = 40: write 0xFFFF_FFFF to bank 1 DIR -> reads 0x0000_00FF; bank 2 reads 0.
- Byte write wb_sel_i = 4'b0010 of 0xAAAA_AAAA to OUT -> only OUT[15:8] = 0xAA. Held strobe -> wb_ack_o toggles 1,0,1.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register map, bank geometry and bus states shared by the GPIO block.
package gpio_pkg;
  localparam int BANK_W = 32;
  localparam int MAX_PORT_NUM = 128;
  localparam logic [2:0] REG_DIR     = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_IN      = 3'd2;
  localparam logic [2:0] REG_IE      = 3'd3;
  localparam logic [2:0] REG_EDGE    = 3'd4;
  localparam logic [2:0] REG_ISTAT   = 3'd5;
  localparam logic [2:0] REG_OUT_SET = 3'd6;
  localparam logic [2:0] REG_OUT_CLR = 3'd7;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: per-pin multi-flop synchroniser plus a "previous" flop for edge pulses.
module gpio_sync #(
  parameter int W = 32,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);
  logic [STAGES-1:0][W-1:0] r_sync;
  logic [W-1:0] r_prev;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  assign o_q = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/gpio_irq_top.sv
// gpio_irq_top: Wishbone GPIO with per-pin direction, atomic set/clear and edge interrupts.
// Registers are held at full 128-bit width; bits beyond PORT_NUM are masked constant zero.
module gpio_irq_top
  import gpio_pkg::*;
#(
  parameter int PORT_NUM = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [31:0]         wb_adr_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack_o,
  input  logic [PORT_NUM-1:0] gpio_in_i,
  output logic [PORT_NUM-1:0] gpio_out_o,
  output logic [PORT_NUM-1:0] gpio_oe_o,
  output logic                irq_o
);
  localparam int MW = MAX_PORT_NUM;
  localparam logic [MW-1:0] VALID = {MW{1'b1}} >> (MW - PORT_NUM);
  bus_state_e r_state, w_state_nxt;
  logic [MW-1:0] r_dir, r_out, r_ie, r_edge, r_istat;
  logic [2:0] r_arm;
  logic [31:0] r_dat;
  logic r_irq;
  logic w_armed, w_acc, w_wr, w_unused;
  logic [1:0] w_bank;
  logic [2:0] w_reg;
  logic [6:0] w_base;
  logic [BANK_W-1:0] w_lane, w_rdat;
  logic [MW-1:0] w_m, w_wd, w_in, w_evt, w_clr;
  logic [PORT_NUM-1:0] w_sync, w_rise, w_fall;

  gpio_sync #(.W(PORT_NUM), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk(clk_i), .i_rst_n(rst_ni), .i_d(gpio_in_i),
    .o_q(w_sync), .o_rise(w_rise), .o_fall(w_fall)
  );

  assign w_unused = ^{wb_adr_i[31:7], wb_adr_i[1:0]};
  assign w_bank = wb_adr_i[3:2];
  assign w_reg = wb_adr_i[6:4];
  assign w_base = {w_bank, 5'd0};
  assign w_acc = wb_cyc_i & wb_stb_i & (r_state == BUS_IDLE);
  assign w_wr = w_acc & wb_we_i;
  assign w_lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_m = VALID & (MW'(w_lane) << w_base);
  assign w_wd = {4{wb_dat_i}} & w_m;
  assign w_in = MW'(w_sync);
  // Arming waits for the reset-zeroed synchroniser to fill, hiding pins held high through reset.
  assign w_armed = r_arm == 3'(SYNC_STAGES + 1);
  assign w_evt = w_armed ? ((MW'(w_rise) & ~r_edge) | (MW'(w_fall) & r_edge)) & ~r_dir : '0;
  assign w_clr = (w_wr && w_reg == REG_ISTAT) ? w_wd : '0;

  always_comb w_state_nxt = (r_state == BUS_IDLE && wb_cyc_i && wb_stb_i) ? BUS_ACK : BUS_IDLE;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= BUS_IDLE;
    else r_state <= w_state_nxt;

  always_comb begin
    w_rdat = '0;
    case (w_reg)
      REG_DIR:   w_rdat = r_dir[w_base +: BANK_W];
      REG_OUT:   w_rdat = r_out[w_base +: BANK_W];
      REG_IN:    w_rdat = w_in[w_base +: BANK_W];
      REG_IE:    w_rdat = r_ie[w_base +: BANK_W];
      REG_EDGE:  w_rdat = r_edge[w_base +: BANK_W];
      REG_ISTAT: w_rdat = r_istat[w_base +: BANK_W];
      default:   w_rdat = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_dir <= '0;
      r_out <= '0;
      r_ie <= '0;
      r_edge <= '0;
      r_istat <= '0;
      r_arm <= '0;
      r_dat <= '0;
      r_irq <= 1'b0;
    end else begin
      r_arm <= w_armed ? r_arm : r_arm + 3'd1;
      r_istat <= (r_istat & ~w_clr) | w_evt;
      r_irq <= |(r_istat & r_ie);
      if (w_acc) r_dat <= w_rdat;
      if (w_wr)
        case (w_reg)
          REG_DIR:     r_dir <= (r_dir & ~w_m) | w_wd;
          REG_OUT:     r_out <= (r_out & ~w_m) | w_wd;
          REG_IE:      r_ie <= (r_ie & ~w_m) | w_wd;
          REG_EDGE:    r_edge <= (r_edge & ~w_m) | w_wd;
          REG_OUT_SET: r_out <= r_out | w_wd;
          REG_OUT_CLR: r_out <= r_out & ~w_wd;
          default: ;
        endcase
    end

  assign wb_ack_o = r_state == BUS_ACK;
  assign wb_dat_o = r_dat;
  assign irq_o = r_irq;
  assign gpio_out_o = r_out[PORT_NUM-1:0];
  assign gpio_oe_o = r_dir[PORT_NUM-1:0];
endmodule
